// File: rtl/mux4_bus_arbiter_pkg.sv
// Shared types and constants for the four-source round-robin bus arbiter.
package mux4_bus_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] PTR_RST = 2'd3;

    localparam int SRC_W = 0;
    localparam int SRC_X = 1;
    localparam int SRC_Y = 2;
    localparam int SRC_Z = 3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/Mux4Way16.sv
// 16-bit, 4-way combinational multiplexer (datapath leaf).
module Mux4Way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [1:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
        endcase
    end

endmodule

// File: rtl/mux4_bus_arbiter_rr_pick4.sv
// Round-robin winner search: first set request in order ptr+1, ptr+2, ptr+3, ptr.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] winner
);

    logic [1:0] idx;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        any    = |req;
        winner = ptr;
        idx    = ptr;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) winner = idx;
        end
    end

endmodule

// File: rtl/mux4_bus_arbiter.sv
// Round-robin arbiter sharing one 16-bit bus among w/x/y/z with a valid/ready
// consumer; tenures are capped at MAX_BURST transfers when others are waiting.
module mux4_bus_arbiter
    import mux4_bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] w,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    output logic [3:0]  gnt,
    output logic [1:0]  sel,
    output logic [3:0]  ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state, state_nx;
    logic [1:0]       ptr, ptr_nx, sel_nx;
    logic [3:0]       gnt_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             any, xfer, others, rel;
    logic [1:0]       winner;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .winner (winner)
    );

    Mux4Way16 u_mux (
        .a   (w),
        .b   (x),
        .c   (y),
        .d   (z),
        .sel (sel),
        .out (out_data)
    );

    assign busy      = (state == ST_BUSY);
    assign out_valid = busy & req[sel];
    assign xfer      = out_valid & out_ready;
    assign ack       = gnt & {4{xfer}};
    assign others    = |(req & ~onehot4(sel));

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        gnt_nx   = gnt;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        rel      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    state_nx = ST_BUSY;
                    sel_nx   = winner;
                    gnt_nx   = onehot4(winner);
                    cnt_nx   = '0;
                end
            end
            default: begin
                if (!req[sel]) begin
                    rel = 1'b1;
                end else if (xfer) begin
                    // A lone requester keeps the bus; the counter just wraps.
                    if (cnt == CNT_LAST) begin
                        if (others) rel = 1'b1;
                        else        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
        endcase
        // sel is left alone on release so out_data stays stable through IDLE.
        if (rel) begin
            state_nx = ST_IDLE;
            gnt_nx   = '0;
            ptr_nx   = sel;
            cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= PTR_RST;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Vector/scoreboard bench for mux4_bus_arbiter (MAX_BURST=4).
module tb_mux4_bus_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       ov;
        logic [3:0] ack;
    } vec_t;

    localparam logic [15:0] WD = 16'hAAAA;
    localparam logic [15:0] XD = 16'hBBBB;
    localparam logic [15:0] YD = 16'hCCCC;
    localparam logic [15:0] ZD = 16'hDDDD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic        out_ready = 1'b0;
    logic [15:0] w = WD, x = XD, y = YD, z = ZD;
    logic [3:0]  gnt, ack;
    logic [1:0]  sel;
    logic        out_valid, busy;
    logic [15:0] out_data;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t mv;

    always #5 clk = ~clk;

    mux4_bus_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .w         (w),
        .x         (x),
        .y         (y),
        .z         (z),
        .gnt       (gnt),
        .sel       (sel),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [1:0] s);
        case (s)
            2'd0:    return WD;
            2'd1:    return XD;
            2'd2:    return YD;
            default: return ZD;
        endcase
    endfunction

    function automatic void add(input logic r, input logic [3:0] rq, input logic rd,
                                input logic [3:0] g, input logic [1:0] s,
                                input logic v, input logic [3:0] a);
        vec_t t;
        t.rst = r; t.req = rq; t.rdy = rd; t.gnt = g; t.sel = s; t.ov = v; t.ack = a;
        vecs.push_back(t);
    endfunction

    // Monitor: compare outputs mid-cycle against the oldest pending expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mv = sb.pop_front();
            chk("gnt",       16'(gnt),       16'(mv.gnt));
            chk("sel",       16'(sel),       16'(mv.sel));
            chk("out_valid", 16'(out_valid), 16'(mv.ov));
            chk("ack",       16'(ack),       16'(mv.ack));
            chk("busy",      16'(busy),      16'(mv.gnt != 4'b0));
            chk("out_data",  out_data,       word_of(mv.sel));
        end
    end

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            if (vecs[i].rst) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            sb.push_back(vecs[i]);
        end
        for (int k = 0; k < 4 && sb.size() != 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
            sb.delete();
        end
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",  16'(gnt), 16'h0);
        chk("rst_sel",  16'(sel), 16'h0);
        chk("rst_ov",   16'(out_valid), 16'h0);
        chk("rst_ack",  16'(ack), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_data", out_data, WD);
        rst_n = 1'b1;

        // Single requester w: grant after one edge, continuous acks, drop -> idle.
        add(0, 4'b0001, 1, 4'b0000, 0, 0, 4'b0000);
        for (int i = 0; i < 5; i++) add(0, 4'b0001, 1, 4'b0001, 0, 1, 4'b0001);
        add(0, 4'b0000, 1, 4'b0001, 0, 0, 4'b0000);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000);
        run_vecs();

        // All four requesting: w,x,y,z,w with 4 acks each and an idle bubble.
        add(1, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000);
        for (int t = 0; t < 5; t++) begin
            logic [1:0] s;
            logic [3:0] oh;
            s  = 2'(t % 4);
            oh = 4'b0001 << s;
            for (int i = 0; i < 4; i++) add(0, 4'b1111, 1, oh, s, 1, oh);
            add(0, 4'b1111, 1, 4'b0000, s, 0, 4'b0000);
        end
        run_vecs();

        // Lone requester x: counter wraps, grant never released.
        add(1, 4'b0010, 1, 4'b0000, 0, 0, 4'b0000);
        for (int i = 0; i < 10; i++) add(0, 4'b0010, 1, 4'b0010, 1, 1, 4'b0010);
        add(0, 4'b0000, 1, 4'b0010, 1, 0, 4'b0000);
        add(0, 4'b0000, 1, 4'b0000, 1, 0, 4'b0000);
        run_vecs();

        // y stalled by out_ready=0, then one ack; only 3 more before handover to w.
        add(1, 4'b0100, 0, 4'b0000, 0, 0, 4'b0000);
        for (int i = 0; i < 5; i++) add(0, 4'b0100, 0, 4'b0100, 2, 1, 4'b0000);
        add(0, 4'b0100, 1, 4'b0100, 2, 1, 4'b0100);
        for (int i = 0; i < 3; i++) add(0, 4'b0101, 1, 4'b0100, 2, 1, 4'b0100);
        add(0, 4'b0101, 1, 4'b0000, 2, 0, 4'b0000);
        add(0, 4'b0101, 1, 4'b0001, 0, 1, 4'b0001);
        add(0, 4'b0000, 1, 4'b0001, 0, 0, 4'b0000);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000);
        run_vecs();

        // x drops its request mid-burst with z waiting.
        add(1, 4'b0010, 1, 4'b0000, 0, 0, 4'b0000);
        add(0, 4'b0010, 1, 4'b0010, 1, 1, 4'b0010);
        add(0, 4'b1010, 1, 4'b0010, 1, 1, 4'b0010);
        add(0, 4'b1000, 1, 4'b0010, 1, 0, 4'b0000);
        add(0, 4'b1000, 1, 4'b0000, 1, 0, 4'b0000);
        add(0, 4'b1000, 1, 4'b1000, 3, 1, 4'b1000);
        run_vecs();

        // z holds the bus; async reset must clear outputs before any edge.
        add(1, 4'b1000, 1, 4'b0000, 0, 0, 4'b0000);
        add(0, 4'b1000, 1, 4'b1000, 3, 1, 4'b1000);
        add(0, 4'b1000, 1, 4'b1000, 3, 1, 4'b1000);
        run_vecs();
        @(posedge clk);
        #1;
        chk("pre_arst_gnt", 16'(gnt), 16'h8);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt",  16'(gnt), 16'h0);
        chk("arst_ack",  16'(ack), 16'h0);
        chk("arst_ov",   16'(out_valid), 16'h0);
        chk("arst_data", out_data, WD);
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_arst_idle_gnt", 16'(gnt), 16'h0);
        add(0, 4'b1111, 1, 4'b0001, 0, 1, 4'b0001);
        add(0, 4'b1111, 1, 4'b0001, 0, 1, 4'b0001);
        run_vecs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
